// File: rtl/mem_line_model.sv
// Backing-memory model for the I-cache refill path: accepts one line request,
// waits LATENCY cycles, then bursts the line back as address-derived data beats.
module mem_line_model #(
  parameter int          ADDR_W     = 32,
  parameter int          LINE_W     = 128,
  parameter int          BEAT_W     = 32,
  parameter int          LATENCY    = 4,
  parameter int          WRAP_FIRST = 0,
  parameter logic [31:0] SEED       = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_req,
  input  logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_ack,
  output logic                mem_ready,
  output logic [BEAT_W-1:0]   mem_data,
  output logic [(((LINE_W/BEAT_W) > 1) ? $clog2(LINE_W/BEAT_W) : 1)-1:0] mem_beat_idx,
  output logic                mem_last,
  output logic                mem_busy
);

  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS        = $clog2(LINE_W / 8);
  localparam int BOFS       = $clog2(BEAT_W / 8);
  localparam int WPB        = BEAT_W / 32;
  localparam int BEAT_BYTES = BEAT_W / 8;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFS) - 64'd1);

  if ((LINE_W % BEAT_W) != 0 || (BEAT_W % 32) != 0 || LATENCY < 1) begin : g_param_check
    $error("mem_line_model: LINE_W must be a multiple of BEAT_W, BEAT_W a multiple of 32, LATENCY >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  beat_n_q, beat_n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [IDX_W-1:0]  start_idx;
  logic              last_beat;
  logic [31:0]       base32;
  logic [31:0]       beat_addr;

  // Critical-word-first starts the burst on the beat holding the missed word.
  always_comb begin
    start_idx = '0;
    if (WRAP_FIRST != 0 && BEATS > 1) begin
      start_idx = IDX_W'(mem_addr >> BOFS);
    end
  end

  assign last_beat = (beat_n_q == IDX_W'(BEATS - 1));

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    idx_d    = idx_q;
    beat_n_d = beat_n_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          base_d   = mem_addr & LINE_MASK;
          idx_d    = start_idx;
          beat_n_d = '0;
          ack_d    = 1'b1;
          if (LATENCY > 1) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d = ST_BURST;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (last_beat) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          beat_n_d = '0;
        end else begin
          beat_n_d = beat_n_q + IDX_W'(1);
          idx_d    = (idx_q == IDX_W'(BEATS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      idx_q    <= '0;
      beat_n_q <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      beat_n_q <= beat_n_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
    end
  end

  // Payload words are their own 32-bit byte address, so only the low 32 bits matter.
  assign base32    = 32'(base_q);
  assign beat_addr = base32 + 32'(idx_q) * 32'(BEAT_BYTES);

  always_comb begin
    mem_data = '0;
    if (state_q == ST_BURST) begin
      for (int k = 0; k < WPB; k++) begin
        mem_data[32*k +: 32] = (beat_addr + 32'(4 * k)) ^ SEED;
      end
    end
  end

  assign mem_ack      = ack_q;
  assign mem_busy     = (state_q != ST_IDLE);
  assign mem_ready    = (state_q == ST_BURST);
  assign mem_last     = (state_q == ST_BURST) && last_beat;
  assign mem_beat_idx = (state_q == ST_BURST) ? idx_q : '0;

endmodule
